gpi_conditioner: RTL and testbench
==================================

// Module: gpi_conditioner
// PURPOSE
//   Input-conditioning stage directly upstream of gpio_top's gpi1/gpi2 ports.
//   Synchronises raw board inputs (switches/buttons) into CLK, debounces every bit
//   against a shared sample tick, and presents a glitch-free word to gpio_top.
//   One instance per GPIO input port; gpi_out connects straight to gpi1 or gpi2.
// PARAMETERS
//   WIDTH       32  number of input bits conditioned
//   TICK_DIV    16  CLK cycles per debounce sample tick (>=1; 1 = sample every cycle)
//   DB_SAMPLES  4   consecutive equal samples required to accept a new level (>=2)
// PORTS
//   CLK         in   1      system clock; all state changes on rising edge
//   RST         in   1      asynchronous, active-low reset (0 = reset asserted)
//   raw_in      in   WIDTH  asynchronous raw inputs from pins
//   gpi_out     out  WIDTH  debounced stable word, feeds gpio_top gpi1/gpi2
//   changed     out  1      1-cycle pulse when any gpi_out bit changes
//   sample_tick out  1      1-cycle pulse on each debounce sample (debug/visibility)
//   edge_clr    in   WIDTH  per-bit clear for edge_flags (only with macro)
//   edge_flags  out  WIDTH  sticky rising-edge flags (only with macro)
// BEHAVIOUR
//   Reset (RST=0, async): sync FFs, per-bit histories, prescaler, gpi_out, changed,
//     sample_tick, edge_flags all 0. Reset mid-operation discards partial histories;
//     after release prescaler restarts at 0 and debouncing restarts from scratch.
//   Synchroniser: 2-FF chain per bit, raw_in -> s1 -> s2; no other logic reads raw_in.
//   Prescaler: counter 0..TICK_DIV-1, width $clog2(TICK_DIV) (min 1 bit); when at
//     TICK_DIV-1 it wraps to 0 and sample_tick=1 for that cycle. TICK_DIV=1: tick
//     every cycle. First tick is TICK_DIV cycles after reset release.
//   Debounce, per bit i, on a cycle with sample_tick=1:
//     hist[i] <= {hist[i][DB_SAMPLES-2:0], s2[i]} (DB_SAMPLES-bit shift);
//     if the NEW history is all 1s -> gpi_out[i]<=1; all 0s -> gpi_out[i]<=0; else hold.
//     gpi_out updates on the same edge as the history shift (no extra register stage).
//   No tick -> histories and gpi_out hold.
//   Latency: a clean level change on raw_in is reflected in gpi_out after 2 sync
//     cycles plus DB_SAMPLES ticks: max 2+DB_SAMPLES*TICK_DIV cycles.
//   Glitch rejection: any pulse sampled on fewer than DB_SAMPLES consecutive ticks
//     never reaches gpi_out.
//   changed: registered; 1 for exactly the cycle after gpi_out differs from its
//     previous value (any bit); multiple bits changing together -> single pulse.
//   Bits are independent; simultaneous changes on many bits need no arbitration.
// CONFIGURATION
//   GPI_EDGE_CAPTURE_EN defined: edge_flags[i] set when gpi_out[i] goes 0->1 (same
//     edge as gpi_out update); cleared when edge_clr[i]=1; set and clear on the same
//     cycle -> set wins (flag stays 1). Falling edges do not set flags.
//   GPI_EDGE_CAPTURE_EN undefined: edge_flags driven constant 0, edge_clr ignored,
//     no flag flops synthesised. All other behaviour identical.
// TESTING (TICK_DIV=4, DB_SAMPLES=3, WIDTH=32 unless noted)
//   1 Reset: RST=0 with raw_in=32'hFFFF_FFFF -> gpi_out=0, changed=0, edge_flags=0
//     while held; sample_tick first pulses 4 cycles after RST rises.
//   2 Clean step: raw_in 0->32'h0000_0005 and held -> gpi_out=32'h5 no later than
//     14 cycles, exactly one changed pulse, never an intermediate value.
//   3 Glitch: raw_in[3]=1 for 5 cycles then 0 -> gpi_out[3] stays 0, no changed pulse.
//   4 Release: from gpi_out=32'h5 drop raw_in to 0 -> gpi_out=0 within 14 cycles,
//     one changed pulse; with macro edge_flags unchanged by the falling edge.
//   5 Edge capture (macro on): step raw_in[0] 0->1 -> edge_flags[0]=1 same cycle
//     gpi_out[0] rises; pulse edge_clr[0] -> 0 next cycle; assert edge_clr[0] on
//     the rising cycle -> flag still 1. Macro off: edge_flags=0 throughout.
//   6 Reset mid-debounce: raw_in[7]=1 for 2 ticks then RST=0 one cycle -> gpi_out=0;
//     after release needs a full 3 fresh ticks before gpi_out[7]=1.

Source files
------------

// File: rtl/gpi_conditioner.sv
// gpi_conditioner: per-bit 2-FF synchroniser, shared sample-tick prescaler and
// DB_SAMPLES-deep debounce filter feeding gpio_top gpi1/gpi2.
// Optional sticky rising-edge flags are built only when GPI_EDGE_CAPTURE_EN is defined.
module gpi_conditioner #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned TICK_DIV   = 16,
   parameter int unsigned DB_SAMPLES = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] raw_in,
   output logic [WIDTH-1:0] gpi_out,
   output logic             changed,
   output logic             sample_tick,
   input  logic [WIDTH-1:0] edge_clr,
   output logic [WIDTH-1:0] edge_flags
);

   localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

   logic [WIDTH-1:0]      s1_q, s2_q;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  tick_q;
   logic [DB_SAMPLES-1:0] hist_q [WIDTH];
   logic [DB_SAMPLES-1:0] hist_d [WIDTH];
   logic [WIDTH-1:0]      gpi_q, gpi_d;
   logic                  changed_q;

   // Two-stage synchroniser; nothing else looks at raw_in.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= raw_in;
         s2_q <= s1_q;
      end
   end

   // Prescaler next state: wrap at TICK_DIV-1.
   always_comb begin
      cnt_d = cnt_q + CntW'(1);
      if (cnt_q == CntMax) cnt_d = '0;
   end

   // Prescaler and registered tick; tick is high the cycle after the wrap edge.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= (cnt_q == CntMax);
      end
   end

   // Shift histories on a tick and accept a level only once the new history is uniform.
   always_comb begin
      gpi_d = gpi_q;
      for (int i = 0; i < int'(WIDTH); i++) begin
         hist_d[i] = hist_q[i];
         if (tick_q) begin
            hist_d[i] = {hist_q[i][DB_SAMPLES-2:0], s2_q[i]};
            if (&hist_d[i]) begin
               gpi_d[i] = 1'b1;
            end else if (~|hist_d[i]) begin
               gpi_d[i] = 1'b0;
            end
         end
      end
   end

   // Debounce state, output word and change pulse.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         hist_q    <= '{default: '0};
         gpi_q     <= '0;
         changed_q <= 1'b0;
      end else begin
         hist_q    <= hist_d;
         gpi_q     <= gpi_d;
         changed_q <= (gpi_d != gpi_q);
      end
   end

`ifdef GPI_EDGE_CAPTURE_EN
   logic [WIDTH-1:0] flags_q, flags_d;

   // Sticky rising-edge flags; a new rise beats a simultaneous clear.
   always_comb begin
      flags_d = (flags_q & ~edge_clr) | (gpi_d & ~gpi_q);
   end

   // Edge flag register.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         flags_q <= '0;
      end else begin
         flags_q <= flags_d;
      end
   end

   assign edge_flags = flags_q;
`else
   logic unused_edge_clr;
   assign unused_edge_clr = ^edge_clr;
   assign edge_flags      = '0;
`endif

   assign gpi_out     = gpi_q;
   assign changed     = changed_q;
   assign sample_tick = tick_q;

endmodule

// File: tb/tb_gpi_conditioner.sv
// Self-checking bench for gpi_conditioner (TICK_DIV=4, DB_SAMPLES=3, WIDTH=32).
// Stimulus pushes the expected word into a queue; a monitor pops it on every changed pulse.
module tb_gpi_conditioner;

   localparam int unsigned W = 32;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic [W-1:0]  raw_in = '0;
   logic [W-1:0]  edge_clr = '0;
   logic [W-1:0]  gpi_out;
   logic          changed;
   logic          sample_tick;
   logic [W-1:0]  edge_flags;

   int n_chk  = 0;
   int n_fail = 0;
   logic [W-1:0] exp_q [$];

   gpi_conditioner #(
      .WIDTH      (W),
      .TICK_DIV   (4),
      .DB_SAMPLES (3)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .raw_in      (raw_in),
      .gpi_out     (gpi_out),
      .changed     (changed),
      .sample_tick (sample_tick),
      .edge_clr    (edge_clr),
      .edge_flags  (edge_flags)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance to 1 time unit after the next n rising edges.
   task automatic cycles(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // Wait up to limit cycles for gpi_out to reach val.
   task automatic wait_gpi(input string name, input logic [W-1:0] val, input int limit);
      int c;
      c = 0;
      while (gpi_out !== val && c < limit) begin
         cycles(1);
         c++;
      end
      check(name, gpi_out, val);
   endtask

   // Monitor: every changed pulse must match the next queued word.
   always @(negedge CLK) begin
      if (RST && changed) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_changed: gpi_out %h with no pending expectation", gpi_out);
         end else begin
            check("changed_value", gpi_out, exp_q.pop_front());
         end
      end
   end

   initial begin
      // 1: reset held with all inputs high
      raw_in = '1;
      cycles(5);
      check("rst_gpi", gpi_out, '0);
      check("rst_changed", W'(changed), '0);
      check("rst_tick", W'(sample_tick), '0);
      check("rst_flags", edge_flags, '0);
      raw_in = '0;
      RST    = 1'b1;
      cycles(3);
      check("tick_early", W'(sample_tick), '0);
      cycles(1);
      check("tick_first", W'(sample_tick), 1);
      cycles(1);
      check("tick_one_cycle", W'(sample_tick), 0);
      cycles(10);

      // 2: clean step to 5
      exp_q.push_back(32'h5);
      raw_in = 32'h5;
      wait_gpi("step_rise", 32'h5, 14);
      cycles(6);
      check("step_pending", W'(exp_q.size()), 0);

      // 3: 5-cycle glitch on bit 3
      raw_in[3] = 1'b1;
      cycles(5);
      raw_in[3] = 1'b0;
      cycles(20);
      check("glitch_hold", gpi_out, 32'h5);

      // 4: release back to 0
      exp_q.push_back(32'h0);
      raw_in = '0;
      wait_gpi("release", 32'h0, 14);
      cycles(4);
`ifdef GPI_EDGE_CAPTURE_EN
      check("fall_flags", edge_flags, 32'h5);
      edge_clr = '1;
      cycles(1);
      edge_clr = '0;
      check("clr_all", edge_flags, '0);

      // 5: edge capture, clear, and set-beats-clear
      exp_q.push_back(32'h1);
      raw_in[0] = 1'b1;
      wait_gpi("edge_rise", 32'h1, 14);
      check("edge_set", edge_flags, 32'h1);
      edge_clr[0] = 1'b1;
      cycles(1);
      edge_clr[0] = 1'b0;
      check("edge_clr", edge_flags, 32'h0);
      exp_q.push_back(32'h0);
      raw_in[0] = 1'b0;
      wait_gpi("edge_fall", 32'h0, 14);
      check("edge_fall_flag", edge_flags, 32'h0);
      edge_clr[0] = 1'b1;
      exp_q.push_back(32'h1);
      raw_in[0] = 1'b1;
      wait_gpi("edge_rise2", 32'h1, 14);
      check("set_wins", edge_flags, 32'h1);
      cycles(1);
      check("clr_after", edge_flags, 32'h0);
      edge_clr[0] = 1'b0;
      exp_q.push_back(32'h0);
      raw_in[0] = 1'b0;
      wait_gpi("edge_fall2", 32'h0, 14);
`else
      check("flags_off_a", edge_flags, '0);
      edge_clr = '1;
      exp_q.push_back(32'h1);
      raw_in[0] = 1'b1;
      wait_gpi("edge_rise", 32'h1, 14);
      check("flags_off_b", edge_flags, '0);
      exp_q.push_back(32'h0);
      raw_in[0] = 1'b0;
      wait_gpi("edge_fall", 32'h0, 14);
      check("flags_off_c", edge_flags, '0);
      edge_clr = '0;
`endif
      cycles(4);

      // 6: reset after bit 7 has been sampled high on two ticks
      begin
         int c;
         c = 0;
         while (sample_tick !== 1'b1 && c < 8) begin
            cycles(1);
            c++;
         end
         check("tick_align", W'(sample_tick), 1);
      end
      raw_in[7] = 1'b1;
      cycles(9);
      RST = 1'b0;
      cycles(1);
      check("mid_rst_gpi", gpi_out, '0);
      exp_q.push_back(32'h80);
      RST = 1'b1;
      cycles(12);
      check("fresh_not_yet", gpi_out, '0);
      cycles(1);
      check("fresh_rise", gpi_out, 32'h80);
      cycles(4);
      check("final_pending", W'(exp_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
